// File: rtl/aes_sbox_pkg.sv
// AES S-box tables and byte lookup helpers shared by the substitution pipeline.
package aes_sbox_pkg;

  localparam int BYTE_W = 8;

  // FIPS-197 forward S-box, indexed by {row, column} = input byte
  localparam logic [BYTE_W-1:0] SBOX_FWD [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // FIPS-197 inverse S-box, indexed the same way
  localparam logic [BYTE_W-1:0] SBOX_INV [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [BYTE_W-1:0] sbox_fwd(input logic [BYTE_W-1:0] b);
    return SBOX_FWD[b];
  endfunction

  function automatic logic [BYTE_W-1:0] sbox_inv(input logic [BYTE_W-1:0] b);
    return SBOX_INV[b];
  endfunction

endpackage

// File: rtl/aes_sbox_byte.sv
// Single-byte S-box lookup; the inverse table is only built when INV_EN is set.
module aes_sbox_byte
  import aes_sbox_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_inv,
  output logic [BYTE_W-1:0] out_byte
);

  generate
    if (INV_EN != 0) begin : g_inv
      // Mode bit picks between the forward and inverse tables
      always_comb begin
        out_byte = sbox_fwd(in_byte);
        if (in_inv) begin
          out_byte = sbox_inv(in_byte);
        end
      end
    end else begin : g_fwd
      // Without an inverse table every request gets the forward substitution;
      // the top flags inverse requests as errors
      logic unused_inv;
      assign unused_inv = in_inv;

      always_comb begin
        out_byte = sbox_fwd(in_byte);
      end
    end
  endgenerate

endmodule

// File: rtl/aes_sbox_pipe.sv
// Two-stage, LANES-wide AES SubBytes/InvSubBytes unit with valid/ready flow control.
// S1 registers the raw beat, the lookup sits between S1 and S2, S2 drives the output.
module aes_sbox_pipe
  import aes_sbox_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int INV_EN = 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_inv,
  input  logic [BYTE_W*LANES-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_inv,
  output logic                    out_err,
  output logic [BYTE_W*LANES-1:0] out_data,
  output logic                    busy
);

  localparam int  DW        = BYTE_W * LANES;
  localparam logic INV_BUILT = (INV_EN != 0);

  logic          s1_valid_q, s1_valid_d;
  logic          s1_inv_q, s1_inv_d;
  logic [DW-1:0] s1_data_q, s1_data_d;
  logic          s2_valid_q, s2_valid_d;
  logic          s2_inv_q, s2_inv_d;
  logic          s2_err_q, s2_err_d;
  logic [DW-1:0] s2_data_q, s2_data_d;
  logic [DW-1:0] lut_data;
  logic          s1_adv;
  logic          s2_adv;

  // S1 -> S2 boundary: independent per-lane lookups
  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      aes_sbox_byte #(
        .INV_EN(INV_EN)
      ) u_byte (
        .in_byte (s1_data_q[BYTE_W*i +: BYTE_W]),
        .in_inv  (s1_inv_q),
        .out_byte(lut_data[BYTE_W*i +: BYTE_W])
      );
    end
  endgenerate

  // A stage may load when it is empty or when the stage after it is draining
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Next-state for both stages; payload registers only load with a live beat
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_inv_d   = s1_inv_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_inv_d   = s2_inv_q;
    s2_err_d   = s2_err_q;
    s2_data_d  = s2_data_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_inv_d  = in_inv;
        s1_data_d = in_data;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_inv_d  = s1_inv_q;
        s2_err_d  = s1_inv_q && !INV_BUILT;
        s2_data_d = lut_data;
      end
    end
  end

  // Stage occupancy flags; cleared immediately on reset so in-flight beats vanish
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
    end
  end

  // Payload registers carry no reset; outputs are gated by the valid flags instead
  always_ff @(posedge CLK) begin
    s1_inv_q  <= s1_inv_d;
    s1_data_q <= s1_data_d;
    s2_inv_q  <= s2_inv_d;
    s2_err_q  <= s2_err_d;
    s2_data_q <= s2_data_d;
  end

  // Output gating: everything reads as zero whenever no beat is presented
  always_comb begin
    out_valid = s2_valid_q;
    out_data  = '0;
    out_inv   = 1'b0;
    out_err   = 1'b0;
    if (s2_valid_q) begin
      out_data = s2_data_q;
      out_inv  = s2_inv_q;
      out_err  = s2_err_q;
    end
    busy = s1_valid_q || s2_valid_q;
  end

endmodule
